// File: rtl/alu_pipe.sv
// Pipelined ALU with configurable width and depth and a valid/ready handshake with backpressure.
// Define ALU_SAT_EN to make add/sub saturate on signed overflow instead of wrapping.
module alu_pipe #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [2:0] {
    OP_NOP = 3'h0,
    OP_ADD = 3'h1,
    OP_SUB = 3'h2,
    OP_AND = 3'h3,
    OP_OR  = 3'h4,
    OP_XOR = 3'h5,
    OP_SHL = 3'h6,
    OP_SHR = 3'h7
  } operation_t;

  localparam int unsigned      MSB       = WIDTH - 1;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  logic             stall;
  logic             last_valid;

  operation_t       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             v_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_zero;
  logic             c_ovf;

  // One global stall freezes every stage, so slots never reorder or compress.
  assign stall     = last_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = last_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q <= OP_NOP;
      a_q  <= '0;
      b_q  <= '0;
      v_q  <= 1'b0;
    end else if (!stall) begin
      op_q <= operation_t'(op_in);
      a_q  <= a_in;
      b_q  <= b_in;
      v_q  <= in_valid;
    end
  end

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_zero  = 1'b0;
    case (op_q)
      OP_ADD: begin
        c_res   = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
        c_ovf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        c_res   = diff[WIDTH-1:0];
        c_carry = diff[WIDTH];
        c_ovf   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_AND:  c_res = a_q & b_q;
      OP_OR:   c_res = a_q | b_q;
      OP_XOR:  c_res = a_q ^ b_q;
      OP_SHL:  c_res = (b_q >= SHIFT_LIM) ? '0 : (a_q << b_q);
      OP_SHR:  c_res = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q);
      default: c_res = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a for both add and sub.
    if (c_ovf) begin
      c_res = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    c_res = c_res;
`endif
    // Empty slots carry all-zero result and flags.
    if (!v_q) begin
      c_res   = '0;
      c_carry = 1'b0;
      c_ovf   = 1'b0;
    end
    c_zero = v_q && (c_res == '0);
  end

  if (STAGES == 1) begin : g_direct
    assign out        = c_res;
    assign out_carry  = c_carry;
    assign out_zero   = c_zero;
    assign out_ovf    = c_ovf;
    assign last_valid = v_q;
  end else begin : g_delay
    localparam int unsigned D = STAGES - 1;

    logic [WIDTH-1:0] res_q [D];
    logic [D-1:0]     carry_q;
    logic [D-1:0]     zero_q;
    logic [D-1:0]     ovf_q;
    logic [D-1:0]     vld_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int unsigned i = 0; i < D; i++) begin
          res_q[i] <= '0;
        end
        carry_q <= '0;
        zero_q  <= '0;
        ovf_q   <= '0;
        vld_q   <= '0;
      end else if (!stall) begin
        res_q[0]   <= c_res;
        carry_q[0] <= c_carry;
        zero_q[0]  <= c_zero;
        ovf_q[0]   <= c_ovf;
        vld_q[0]   <= v_q;
        for (int unsigned i = 1; i < D; i++) begin
          res_q[i]   <= res_q[i-1];
          carry_q[i] <= carry_q[i-1];
          zero_q[i]  <= zero_q[i-1];
          ovf_q[i]   <= ovf_q[i-1];
          vld_q[i]   <= vld_q[i-1];
        end
      end
    end

    assign out        = res_q[D-1];
    assign out_carry  = carry_q[D-1];
    assign out_zero   = zero_q[D-1];
    assign out_ovf    = ovf_q[D-1];
    assign last_valid = vld_q[D-1];
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=6, STAGES=2): directed cases plus random ops
// scored against an arithmetic reference model through an in-order expectation queue.
module tb_alu_pipe;

  logic       clk;
  logic       rst;
  logic [2:0] op_in;
  logic [5:0] a_in;
  logic [5:0] b_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out;
  logic       out_carry;
  logic       out_zero;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready;

  int n_assert;
  int n_fail;
  int n_consumed;
  logic [8:0] exp_q [$];

  alu_pipe #(.WIDTH(6), .STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_in    (op_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_carry(out_carry),
    .out_zero (out_zero),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic on 6-bit values.
  function automatic logic [8:0] model(input int op, input int a, input int b);
    int r, sa, sb, sr;
    bit c, o;
    r = 0; c = 0; o = 0; sr = 0;
    sa = (a >= 32) ? a - 64 : a;
    sb = (b >= 32) ? b - 64 : b;
    case (op)
      1: begin r = (a + b) % 64; c = (a + b) >= 64; sr = sa + sb; o = (sr > 31) || (sr < -32); end
      2: begin r = (a - b + 64) % 64; c = a < b; sr = sa - sb; o = (sr > 31) || (sr < -32); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (b >= 6) ? 0 : ((a << b) % 64);
      7: r = (b >= 6) ? 0 : (a >> b);
      default: r = 0;
    endcase
`ifdef ALU_SAT_EN
    if (o) r = (sr > 31) ? 31 : 32;
`endif
    return {6'(r), c, (r == 0), o};
  endfunction

  function automatic logic [8:0] cur();
    return {out, out_carry, out_zero, out_ovf};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: score the handshakes at the negedge, then advance past the posedge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          chk("sb_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 32'(cur()), 32'(e));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(op_in), int'(a_in), int'(b_in)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [2:0] op, input logic [5:0] a,
                         input logic [5:0] b, input logic [8:0] exp);
    op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(cur()), 32'(exp));
    tick();
  endtask

  initial begin
    int idx;
    int base;
    n_assert = 0; n_fail = 0; n_consumed = 0;

    rst = 1'b0; in_valid = 1'b1; out_ready = 1'($urandom);
    op_in = 3'($urandom); a_in = 6'($urandom); b_in = 6'($urandom);
    tick();
    op_in = 3'($urandom); a_in = 6'($urandom); b_in = 6'($urandom);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flags", 32'(cur()), 32'd0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_one("add_30_40", 3'd1, 6'd30, 6'd40, {6'd6, 1'b1, 1'b0, 1'b0});
`ifdef ALU_SAT_EN
    run_one("add_31_1", 3'd1, 6'd31, 6'd1, {6'd31, 1'b0, 1'b0, 1'b1});
    run_one("add_32_32", 3'd1, 6'd32, 6'd32, {6'd32, 1'b1, 1'b0, 1'b1});
`else
    run_one("add_31_1", 3'd1, 6'd31, 6'd1, {6'd32, 1'b0, 1'b0, 1'b1});
    run_one("add_32_32", 3'd1, 6'd32, 6'd32, {6'd0, 1'b1, 1'b1, 1'b1});
`endif
    run_one("sub_5_7", 3'd2, 6'd5, 6'd7, {6'd62, 1'b1, 1'b0, 1'b0});
    run_one("sub_9_9", 3'd2, 6'd9, 6'd9, {6'd0, 1'b0, 1'b1, 1'b0});
    run_one("shl_1_6", 3'd6, 6'd1, 6'd6, {6'd0, 1'b0, 1'b1, 1'b0});
    run_one("shr_48_4", 3'd7, 6'd48, 6'd4, {6'd3, 1'b0, 1'b0, 1'b0});
    run_one("nop", 3'd0, 6'd17, 6'd9, {6'd0, 1'b0, 1'b1, 1'b0});

    // Backpressure: four adds, consumer stalls in cycles 3..5.
    idx = 0; n_consumed = 0;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        op_in = 3'd1; a_in = 6'(idx + 1); b_in = 6'(idx + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 32'(in_ready), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
      if (c >= 3 && c <= 5) chk("bp_hold", 32'(cur()), 32'({6'd2, 1'b0, 1'b0, 1'b0}));
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("bp_count", 32'(n_consumed), 32'd4);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset while two transactions are in flight.
    out_ready = 1'b1;
    op_in = 3'd1; a_in = 6'd10; b_in = 6'd11; in_valid = 1'b1;
    tick();
    a_in = 6'd12; b_in = 6'd13; rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_out", 32'(out_valid), 32'd0);
    end
    run_one("mid_add_3_4", 3'd1, 6'd3, 6'd4, {6'd7, 1'b0, 1'b0, 1'b0});

    // Throughput: 20 random ops back-to-back.
    out_ready = 1'b1;
    base = n_consumed;
    for (int k = 1; k <= 23; k++) begin
      if (k <= 20) begin
        op_in = 3'($urandom); a_in = 6'($urandom);
        b_in = 6'($urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 7));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("tp_valid", 32'(out_valid), (k >= 2 && k <= 21) ? 32'd1 : 32'd0);
    end
    chk("tp_count", 32'(n_consumed - base), 32'd20);
    chk("tp_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
